controller: RTL and testbench

- Per-node packet-handling controller for the clustered RL routing node.
- Decodes the filtered packet type and header fields, and drives one-cycle-registered write enables to the node's storage blocks:
  - known-CH table (KCH)
  - my-node-info (MNI)
  - Q-table/FMB update (QTU_FMB)
  - neighbor table
  - reward unit
- Also flags when this node is the packet's destination and grants transmission (okToSend) in the node's slot when the channel is clear.

---
 rtl/ctrl_pkg.sv | 27 ++
 rtl/ctrl_decode.sv | 41 ++++
 rtl/controller.sv | 81 ++++++++
 tb/tb_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RL routing node packet controller.
package ctrl_pkg;

  localparam int WORD_WIDTH = 16;
  localparam logic [WORD_WIDTH-1:0] NULL_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    PKT_HB   = 3'd0,
    PKT_CHE  = 3'd1,
    PKT_INV  = 3'd2,
    PKT_MR   = 3'd3,
    PKT_CHTS = 3'd4,
    PKT_DATA = 3'd5,
    PKT_SOS  = 3'd6,
    PKT_NONE = 3'd7
  } pkt_type_t;

  typedef struct packed {
    logic kch;
    logic mni;
    logic qtu_fmb;
    logic nbr;
    logic reward;
    logic iam_dest;
  } ctrl_en_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from filtered packet type (plus header matches) to storage enables.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [2:0] pkt_type,
  input  logic       mr_match,
  input  logic       dest_match,
  output logic       en_kch,
  output logic       en_mni,
  output logic       en_qtu_fmb,
  output logic       en_nbr,
  output logic       en_reward,
  output logic       iam_dest
);

  always_comb begin
    en_kch     = 1'b0;
    en_mni     = 1'b0;
    en_qtu_fmb = 1'b0;
    en_nbr     = 1'b0;
    en_reward  = 1'b0;
    iam_dest   = 1'b0;
    case (pkt_type_t'(pkt_type))
      PKT_HB: begin
        en_qtu_fmb = 1'b1;
        en_nbr     = 1'b1;
      end
      PKT_CHE, PKT_CHTS: en_mni = 1'b1;
      PKT_INV, PKT_SOS:  en_kch = 1'b1;
      // Only route-reply MR packets that name our current CH refresh the neighbor table.
      PKT_MR:            en_nbr = mr_match;
      PKT_DATA: begin
        iam_dest   = dest_match;
        en_reward  = dest_match;
        en_qtu_fmb = dest_match;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Per-node packet controller: registered storage enables, destination flag and slotted send grant.
module controller #(
  parameter int                    WORD_WIDTH = ctrl_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] NULL_WORD  = ctrl_pkg::NULL_WORD
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic [WORD_WIDTH-1:0] fChosenCH,
  input  logic [WORD_WIDTH-1:0] fTimeslot,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic                  channel_clear,
  input  logic [WORD_WIDTH-1:0] myTimeslot,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  role,
  input  logic                  iHaveData,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  output logic                  en_KCH,
  output logic                  en_MNI,
  output logic                  en_QTU_FMB,
  output logic                  en_neighborTable,
  output logic                  en_reward,
  output logic                  iAmDestination,
  output logic                  okToSend
);

  ctrl_pkg::ctrl_en_t en_d, en_q;
  logic send_pending_d, send_pending_q;
  logic ok_to_send_d, ok_to_send_q;
  logic mr_match, dest_match, slot_ok, send_set;
  logic unused_hops;

  // Hop count travels with the packet but plays no part in the decode.
  assign unused_hops = ^fHopsFromCH;

  assign mr_match   = (fChosenCH == chosenCH);
  assign dest_match = (destinationID == myNodeID);

  ctrl_decode u_dec (
    .pkt_type   (fPacketType),
    .mr_match   (mr_match),
    .dest_match (dest_match),
    .en_kch     (en_d.kch),
    .en_mni     (en_d.mni),
    .en_qtu_fmb (en_d.qtu_fmb),
    .en_nbr     (en_d.nbr),
    .en_reward  (en_d.reward),
    .iam_dest   (en_d.iam_dest)
  );

  always_comb begin
    slot_ok        = (myTimeslot == NULL_WORD) ? 1'b1 : (fTimeslot == myTimeslot);
    ok_to_send_d   = send_pending_q & channel_clear & slot_ok;
    // Members relay data addressed to them toward their CH.
    send_set       = iHaveData | (en_d.iam_dest & ~role);
    // A new request in the grant cycle survives the clear.
    send_pending_d = send_set | (send_pending_q & ~ok_to_send_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_q           <= '0;
      send_pending_q <= 1'b0;
      ok_to_send_q   <= 1'b0;
    end else begin
      en_q           <= en_d;
      send_pending_q <= send_pending_d;
      ok_to_send_q   <= ok_to_send_d;
    end
  end

  assign en_KCH           = en_q.kch;
  assign en_MNI           = en_q.mni;
  assign en_QTU_FMB       = en_q.qtu_fmb;
  assign en_neighborTable = en_q.nbr;
  assign en_reward        = en_q.reward;
  assign iAmDestination   = en_q.iam_dest;
  assign okToSend         = ok_to_send_q;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: a reference model queues expected outputs per driven cycle.
module tb_controller;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [2:0]  fPacketType = 3'd7;
  logic [15:0] fHopsFromCH = '0, fChosenCH = '0, fTimeslot = '0, destinationID = '0;
  logic [15:0] myTimeslot = 16'hFFFF, myNodeID = '0, chosenCH = '0;
  logic        channel_clear = 1'b0, role = 1'b0, iHaveData = 1'b0;
  logic        en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination, okToSend;
  logic [6:0]  obs;
  logic [6:0]  sb[$];
  logic [6:0]  e;
  logic        sp_m = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  controller dut (
    .clk(clk), .nrst(nrst), .fPacketType(fPacketType), .fHopsFromCH(fHopsFromCH),
    .fChosenCH(fChosenCH), .fTimeslot(fTimeslot), .destinationID(destinationID),
    .channel_clear(channel_clear), .myTimeslot(myTimeslot), .myNodeID(myNodeID),
    .role(role), .iHaveData(iHaveData), .chosenCH(chosenCH),
    .en_KCH(en_KCH), .en_MNI(en_MNI), .en_QTU_FMB(en_QTU_FMB),
    .en_neighborTable(en_neighborTable), .en_reward(en_reward),
    .iAmDestination(iAmDestination), .okToSend(okToSend)
  );

  assign obs = {en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination, okToSend};

  // Reference model: predict next outputs from the current inputs, then advance one edge.
  task automatic clock_cycle();
    logic [6:0] x;
    logic dst, slot, ok;
    x    = '0;
    dst  = (fPacketType == 3'd5) && (destinationID == myNodeID);
    slot = (myTimeslot == 16'hFFFF) || (fTimeslot == myTimeslot);
    ok   = sp_m && channel_clear && slot;
    if (fPacketType == 3'd0) x = 7'b0011000;
    else if (fPacketType == 3'd1 || fPacketType == 3'd4) x = 7'b0100000;
    else if (fPacketType == 3'd2 || fPacketType == 3'd6) x = 7'b1000000;
    else if (fPacketType == 3'd3 && fChosenCH == chosenCH) x = 7'b0001000;
    else if (dst) x = 7'b0010110;
    x[0] = ok;
    sb.push_back(x);
    if (iHaveData || (dst && !role)) sp_m = 1'b1;
    else if (ok) sp_m = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    #2;
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_async: got %b expected 0000000", obs); end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL reset_held: got %b expected 0000000", obs); end
    nrst = 1'b1;
    sp_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release[%0d]: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_hb();
    fPacketType = 3'd0; myTimeslot = 16'hFFFF; iHaveData = 1'b0;
    for (int i = 0; i < 3; i++) begin
      channel_clear = (i == 1);
      if (i == 2) fPacketType = 3'd7;
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hb[%0d]: got %b expected %b", i, obs, e); end
      if (i == 0) begin
        checks++;
        if (obs !== 7'b0011000) begin errors++; $display("FAIL hb_enables: got %b expected 0011000", obs); end
      end
    end
    channel_clear = 1'b0;
  endtask

  task automatic test_che_inv();
    for (int i = 0; i < 7; i++) begin
      fPacketType = (i < 3) ? 3'd1 : (i < 6) ? 3'd2 : 3'd7;
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL che_inv[%0d]: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_mr();
    chosenCH = 16'd23; fPacketType = 3'd3;
    for (int i = 0; i < 4; i++) begin
      fChosenCH = (i == 0) ? 16'd35 : 16'd23;
      if (i == 3) fPacketType = 3'd7;
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mr[%0d]: got %b expected %b", i, obs, e); end
      if (i == 1) begin
        checks++;
        if (en_neighborTable !== 1'b1) begin errors++; $display("FAIL mr_match: got %b expected 1", en_neighborTable); end
      end
    end
  endtask

  task automatic test_data();
    int pulses;
    pulses = 0;
    myNodeID = 16'd12; role = 1'b0; channel_clear = 1'b1; myTimeslot = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      fPacketType   = (i == 0 || i == 4 || i == 5 || i == 6) ? 3'd5 : 3'd7;
      destinationID = (i == 4 || i == 5) ? 16'd7 : 16'd12;
      role          = (i == 6);
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL data[%0d]: got %b expected %b", i, obs, e); end
      if (i < 4 && okToSend) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL data_relay_pulses: got %0d expected 1", pulses); end
    fPacketType = 3'd7; role = 1'b0; channel_clear = 1'b0;
  endtask

  task automatic test_slot_send();
    int early;
    early = 0;
    iHaveData = 1'b1; myTimeslot = 16'd3; channel_clear = 1'b1;
    for (int i = 0; i < 9; i++) begin
      fTimeslot = (i < 3) ? 16'd2 : 16'd3;
      if (i >= 6) iHaveData = 1'b0;
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL slot[%0d]: got %b expected %b", i, obs, e); end
      if (i < 3 && okToSend) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL slot_wrong_slot: got %0d grants expected 0", early); end
    channel_clear = 1'b0; myTimeslot = 16'hFFFF;
  endtask

  task automatic test_sos();
    for (int i = 0; i < 3; i++) begin
      fPacketType = (i < 2) ? 3'd6 : 3'd7;
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sos[%0d]: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      fPacketType   = 3'($urandom_range(0, 7));
      destinationID = $urandom_range(0, 1) ? 16'd12 : 16'd7;
      fChosenCH     = $urandom_range(0, 1) ? 16'd23 : 16'hFFFF;
      channel_clear = 1'($urandom_range(0, 1));
      fTimeslot     = 16'($urandom_range(2, 4));
      myTimeslot    = $urandom_range(0, 1) ? 16'd3 : 16'hFFFF;
      iHaveData     = ($urandom_range(0, 3) == 0);
      role          = 1'($urandom_range(0, 1));
      fHopsFromCH   = 16'($urandom);
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b[%0d]: got %b expected %b", i, obs, e); end
    end
    fPacketType = 3'd7; iHaveData = 1'b0; channel_clear = 1'b0; role = 1'b0; myTimeslot = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b_drain[%0d]: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    iHaveData = 1'b1; channel_clear = 1'b1; myTimeslot = 16'hFFFF; fPacketType = 3'd7;
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mid_pre[%0d]: got %b expected %b", i, obs, e); end
    end
    checks++;
    if (okToSend !== 1'b1) begin errors++; $display("FAIL mid_grant: got %b expected 1", okToSend); end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0) begin errors++; $display("FAIL mid_reset_async: got %b expected 0000000", obs); end
    sp_m = 1'b0;
    iHaveData = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clock_cycle();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mid_post[%0d]: got %b expected %b", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_hb();
    test_che_inv();
    test_mr();
    test_data();
    test_slot_send();
    test_sos();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
